// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bus bridge: the peripheral page
// base, register addresses and the active-low 7-segment decode table.
package bridge_pkg;

    localparam logic [31:0] PAGE_BASE = 32'hFFFF_F000;
    localparam logic [19:0] PAGE_TAG  = 20'hFFFFF;

    localparam logic [31:0] ADDR_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TCNT = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;

    // Active-low segments: bit 0 = a ... bit 6 = g, bit 7 = DP (kept off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] seg;
        case (value)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit 7-segment driver: a scan divider holds each digit lit for
// SCAN_DIV cycles, then the digit index advances 0..7 and wraps.
module seg7_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [3:0]       nibble [8];

    // Split the DIG word into one hex nibble per digit position.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
            assign nibble[gi] = dig[4*gi +: 4];
        end
    endgenerate

    // Divider wraps at terminal count and steps the digit index (3-bit wrap).
    always_comb begin
        scan_cnt_next = scan_cnt_reg + 1'b1;
        idx_next      = idx_reg;
        if (scan_cnt_reg == CNT_LAST) begin
            scan_cnt_next = '0;
            idx_next      = idx_reg + 3'd1;
        end
    end

    // Scan state registers.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else begin
            scan_cnt_reg <= scan_cnt_next;
            idx_reg      <= idx_next;
        end
    end

    // Outputs follow the registered index, so they track reset without a clock.
    always_comb begin
        dig_en  = ~(8'b1 << idx_reg);
        dig_seg = hex_to_seg(nibble[idx_reg]);
    end

endmodule

// File: rtl/bus_bridge.sv
// CPU bus bridge: decodes the 0xFFFF_Fxxx peripheral page (DIG, LED, SW and an
// optional timer) and passes every other address through to DRAM.
// Optional timer (TCNT/TDIV/prescaler) is built only when BRIDGE_TIMER_EN is defined.
module bus_bridge
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    logic        in_page;
    logic        wr_dig, wr_led;
    logic [31:0] dig_reg;
    logic [23:0] led_reg;
    logic [31:0] tcnt_rd, tdiv_rd;
    logic [31:0] page_rdata;

    assign in_page = (Bus_addr[31:12] == PAGE_TAG);
    assign wr_dig  = Bus_we && (Bus_addr == ADDR_DIG);
    assign wr_led  = Bus_we && (Bus_addr == ADDR_LED);

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_we    = Bus_we && !in_page;
    assign led        = led_reg;

    // Display and LED registers; writes land on the strobe edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            dig_reg <= '0;
            led_reg <= '0;
        end else begin
            if (wr_dig) dig_reg <= Bus_wdata;
            if (wr_led) led_reg <= Bus_wdata[23:0];
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic [31:0] tcnt_reg, tdiv_reg, presc_reg;
    logic        wr_tcnt, wr_tdiv, tick;

    assign wr_tcnt = Bus_we && (Bus_addr == ADDR_TCNT);
    assign wr_tdiv = Bus_we && (Bus_addr == ADDR_TDIV);
    assign tick    = (tdiv_reg != '0) && (presc_reg == tdiv_reg - 32'd1);

    // Timer: bus writes win over the tick and restart the prescaler so a new
    // count or divisor always starts from a clean phase.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            tcnt_reg  <= '0;
            tdiv_reg  <= '0;
            presc_reg <= '0;
        end else if (wr_tcnt) begin
            tcnt_reg  <= Bus_wdata;
            presc_reg <= '0;
        end else if (wr_tdiv) begin
            tdiv_reg  <= Bus_wdata;
            presc_reg <= '0;
        end else if (tick) begin
            tcnt_reg  <= tcnt_reg + 32'd1;
            presc_reg <= '0;
        end else if (tdiv_reg != '0) begin
            presc_reg <= presc_reg + 32'd1;
        end
    end

    assign tcnt_rd = tcnt_reg;
    assign tdiv_rd = tdiv_reg;
`else
    assign tcnt_rd = '0;
    assign tdiv_rd = '0;
`endif

    // Zero-latency read mux; unmapped page offsets read as zero.
    always_comb begin
        page_rdata = '0;
        case (Bus_addr)
            ADDR_DIG:  page_rdata = dig_reg;
            ADDR_TCNT: page_rdata = tcnt_rd;
            ADDR_TDIV: page_rdata = tdiv_rd;
            ADDR_LED:  page_rdata = {8'h00, led_reg};
            ADDR_SW:   page_rdata = {8'h00, sw};
            default:   page_rdata = '0;
        endcase
        Bus_rdata = in_page ? page_rdata : dram_rdata;
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg7_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .dig       (dig_reg),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: fixed vector table, hand-written timer and
// reset sequences, then random bus traffic against a behavioural model.
module tb_bus_bridge;

    localparam int SCAN_DIV = 4;
`ifdef BRIDGE_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [31:0] A_DIG  = 32'hFFFF_F000;
    localparam logic [31:0] A_TCNT = 32'hFFFF_F020;
    localparam logic [31:0] A_TDIV = 32'hFFFF_F024;
    localparam logic [31:0] A_LED  = 32'hFFFF_F060;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;

    logic        clk, rst_n;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata, dram_wdata, dram_rdata;
    logic        Bus_we, dram_we;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [7:0]  dig_en, dig_seg;

    bus_bridge #(.SCAN_DIV(SCAN_DIV)) dut (
        .cpu_clk    (clk),
        .cpu_rst_n  (rst_n),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] dig_m, led_m, tcnt_m, tdiv_m;
    longint      elapsed_m;   // cycles since the timer phase was last restarted
    longint      scan_edges;  // clock edges since reset release

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_edges <= 0;
        else        scan_edges <= scan_edges + 1;
    end

    // Captured outputs from the most recent apply()
    logic [31:0] rd_s, dwd_s;
    logic        dwe_s;
    logic [13:0] daddr_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[v];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] dr);
        if (a[31:12] != 20'hFFFFF) return dr;
        case (a)
            A_DIG:   return dig_m;
            A_LED:   return led_m;
            A_SW:    return {8'h00, sw};
            A_TCNT:  return TIMER ? tcnt_m : 32'h0;
            A_TDIV:  return TIMER ? tdiv_m : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        dig_m = 0; led_m = 0; tcnt_m = 0; tdiv_m = 0; elapsed_m = 0;
    endfunction

    // One bus cycle: drive, sample mid-cycle, check display/LED, clock, update model.
    task automatic apply(input logic [31:0] a, input logic w, input logic [31:0] d);
        int          idx;
        logic [7:0]  exp_en;
        Bus_addr = a; Bus_we = w; Bus_wdata = d;
        @(negedge clk);
        rd_s = Bus_rdata; dwe_s = dram_we; daddr_s = dram_addr; dwd_s = dram_wdata;
        idx    = int'((scan_edges / SCAN_DIV) % 8);
        exp_en = 8'h01 << idx;
        exp_en = ~exp_en;
        chk("dig_en", {24'h0, dig_en}, {24'h0, exp_en});
        chk("dig_seg", {24'h0, dig_seg}, {24'h0, seg_of(dig_m[4*idx +: 4])});
        chk("led", {8'h0, led}, led_m);
        chk("dram_wdata", dwd_s, d);
        @(posedge clk);
        if (w && a == A_DIG) dig_m = d;
        if (w && a == A_LED) led_m = {8'h00, d[23:0]};
        if (w && a == A_TCNT) begin
            tcnt_m = d; elapsed_m = 0;
        end else if (w && a == A_TDIV) begin
            tdiv_m = d; elapsed_m = 0;
        end else begin
            elapsed_m++;
            if (tdiv_m != 0 && (elapsed_m % tdiv_m) == 0) tcnt_m = tcnt_m + 1;
        end
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic [31:0] exp_rd;
        logic        exp_dwe;
        logic [13:0] exp_daddr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{A_LED,  1'b1, 32'h00AB_CDEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 14'h3C18};
        vecs[1]  = '{A_LED,  1'b0, 32'h0,         32'h2222_2222, 32'h00AB_CDEF, 1'b0, 14'h3C18};
        vecs[2]  = '{A_SW,   1'b0, 32'h0,         32'h3333_3333, 32'h005A_5A5A, 1'b0, 14'h3C1C};
        vecs[3]  = '{A_SW,   1'b1, 32'hFFFF_FFFF, 32'h4444_4444, 32'h005A_5A5A, 1'b0, 14'h3C1C};
        vecs[4]  = '{A_SW,   1'b0, 32'h0,         32'h5555_5555, 32'h005A_5A5A, 1'b0, 14'h3C1C};
        vecs[5]  = '{32'h0000_0040, 1'b1, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 14'h0010};
        vecs[6]  = '{32'hFFFF_F040, 1'b1, 32'h0000_1234, 32'h6666_6666, 32'h0000_0000, 1'b0, 14'h3C10};
        vecs[7]  = '{32'hFFFF_F040, 1'b0, 32'h0,         32'h7777_7777, 32'h0000_0000, 1'b0, 14'h3C10};
        vecs[8]  = '{A_DIG,  1'b1, 32'h1234_5678, 32'h8888_8888, 32'h0000_0000, 1'b0, 14'h3C00};
        vecs[9]  = '{A_DIG,  1'b0, 32'h0,         32'h9999_9999, 32'h1234_5678, 1'b0, 14'h3C00};
        vecs[10] = '{32'h0000_1234, 1'b0, 32'h0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 14'h048D};
        vecs[11] = '{32'hFFFF_EFFC, 1'b1, 32'h77, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 14'h3BFF};
        vecs[12] = '{32'hFFFF_FFFC, 1'b0, 32'h0,  32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 14'h3FFF};

        Bus_addr = A_DIG; Bus_we = 0; Bus_wdata = 0; dram_rdata = 0; sw = 24'h5A5A5A;
        rst_n = 1'b1;
        model_reset();

        // Reset state, before any clock edge has released it
        #2 rst_n = 1'b0;
        #1;
        chk("rst dig_en", {24'h0, dig_en}, 32'hFE);
        chk("rst dig_seg", {24'h0, dig_seg}, 32'hC0);
        chk("rst led", {8'h0, led}, 32'h0);
        chk("rst rdata DIG", Bus_rdata, 32'h0);
        Bus_addr = A_TCNT; #1;
        chk("rst rdata TCNT", Bus_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fixed vectors
        for (int i = 0; i < 13; i++) begin
            dram_rdata = vecs[i].drd;
            apply(vecs[i].addr, vecs[i].we, vecs[i].wdata);
            chk($sformatf("vec%0d rdata", i), rd_s, vecs[i].exp_rd);
            chk($sformatf("vec%0d dram_we", i), {31'h0, dwe_s}, {31'h0, vecs[i].exp_dwe});
            chk($sformatf("vec%0d dram_addr", i), {18'h0, daddr_s}, {18'h0, vecs[i].exp_daddr});
        end
        chk("led pin", {8'h0, led}, 32'h00AB_CDEF);

        // Watch the scan sweep through every digit of 0x12345678 several times
        repeat (70) apply(A_DIG, 1'b0, 32'h0);

        // Timer: divide by 3, then wrap from all-ones
        apply(A_TDIV, 1'b1, 32'd3);
        apply(A_TDIV, 1'b0, 32'h0);
        chk("tdiv readback", rd_s, TIMER ? 32'd3 : 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt before 3", rd_s, 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt after 3", rd_s, TIMER ? 32'd1 : 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt after 6", rd_s, TIMER ? 32'd2 : 32'd0);
        apply(A_TCNT, 1'b1, 32'hFFFF_FFFF);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt load", rd_s, TIMER ? 32'hFFFF_FFFF : 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt wrap", rd_s, 32'd0);

        // TCNT write on the terminal-count edge wins and restarts the prescaler
        apply(A_TDIV, 1'b1, 32'd3);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b1, 32'h100);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt write vs tick", rd_s, TIMER ? 32'h100 : 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt presc cleared", rd_s, TIMER ? 32'h100 : 32'd0);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt next tick", rd_s, TIMER ? 32'h101 : 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d, dr, exp_rd;
            logic        w;
            case ($urandom_range(0, 7))
                0: a = A_DIG;
                1: a = A_TCNT;
                2: a = A_TDIV;
                3: a = A_LED;
                4: a = A_SW;
                5: a = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFC);
                default: begin
                    a = $urandom;
                    if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
                end
            endcase
            w  = 1'($urandom_range(0, 1));
            d  = (a == A_TDIV) ? 32'($urandom_range(0, 4)) : $urandom;
            dr = $urandom;
            if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
            dram_rdata = dr;
            exp_rd = exp_read(a, dr);
            apply(a, w, d);
            chk($sformatf("rand%0d rdata @%h", n, a), rd_s, exp_rd);
            chk($sformatf("rand%0d dram_we", n), {31'h0, dwe_s},
                {31'h0, w && (a[31:12] != 20'hFFFFF)});
            chk($sformatf("rand%0d dram_addr", n), {18'h0, daddr_s}, {18'h0, a[15:2]});
        end

        // Asynchronous reset mid-scan with the timer running
        apply(A_TDIV, 1'b1, 32'd2);
        apply(A_DIG, 1'b1, 32'h9ABC_DEF1);
        apply(A_LED, 1'b1, 32'h00FF_FFFF);
        repeat (5) apply(A_TCNT, 1'b0, 32'h0);
        Bus_addr = A_DIG; Bus_we = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async dig_en", {24'h0, dig_en}, 32'hFE);
        chk("async dig_seg", {24'h0, dig_seg}, 32'hC0);
        chk("async led", {8'h0, led}, 32'h0);
        chk("async rdata DIG", Bus_rdata, 32'h0);
        Bus_addr = A_TCNT; #1;
        chk("async rdata TCNT", Bus_rdata, 32'h0);
        Bus_addr = A_TDIV; #1;
        chk("async rdata TDIV", Bus_rdata, 32'h0);
        Bus_addr = A_LED; #1;
        chk("async rdata LED", Bus_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("held dig_en", {24'h0, dig_en}, 32'hFE);
        rst_n = 1'b1;
        repeat (10) apply(A_TCNT, 1'b0, 32'h0);
        chk("post-reset tcnt", rd_s, 32'h0);
        apply(A_TCNT, 1'b1, 32'h55);
        apply(A_TCNT, 1'b0, 32'h0);
        chk("tcnt after write", rd_s, TIMER ? 32'h55 : 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
